// File: rtl/avsddac_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// avsddac_seq_ctrl_if
//
// Write port of the avsddac multi-channel sequencer. It is a valid/ready
// channel that carries a channel index and the code for that channel's shadow
// register.
//
// Parameters
//   NCH    number of DAC channels; sets the width of wr_ch
//   WIDTH  code width per channel
//
// Signals
//   wr_valid  master -> slave  write request
//   wr_ready  slave  -> master write accepted when wr_valid && wr_ready
//   wr_ch     master -> slave  target channel, max(1, clog2(NCH)) bits
//   wr_code   master -> slave  code for the shadow register
// -----------------------------------------------------------------------------
interface avsddac_seq_ctrl_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 10
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             wr_valid;
    logic             wr_ready;
    logic [CHW-1:0]   wr_ch;
    logic [WIDTH-1:0] wr_code;

    modport master (
        output wr_valid,
        output wr_ch,
        output wr_code,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_ch,
        input  wr_code,
        output wr_ready
    );
endinterface

// File: rtl/avsddac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// avsddac_seq_ctrl
//
// Multi-channel sequencer for avsddac-style DAC instances. The core writes
// codes into per-channel shadow registers through a valid/ready port. A load
// strobe (ldac) commits all shadow codes to the outputs together, which gives
// LDAC semantics. The outputs are one WIDTH-bit code per channel and feed the
// avsddac D inputs.
//
// Build option
//   DAC_RAMP_EN  defined:   after a commit, every output moves toward its new
//                           code by at most STEP per clock (slew-limited ramp).
//                undefined: a commit loads the outputs directly. There is no
//                           ramp, busy stays 0 and STEP has no effect.
//
// Parameters
//   NCH    number of channels (>= 1)
//   WIDTH  code width per channel; full scale is 2**WIDTH-1
//   STEP   largest code change per clock per channel while ramping
//
// Ports
//   CLK       in   system clock; all logic is on the rising edge
//   reset     in   synchronous, active-high reset
//   wr        if   write port (slave modport): wr_valid/wr_ready/wr_ch/wr_code
//   ldac      in   commits all shadow codes to the outputs
//   d_out     out  channel i code at [i*WIDTH +: WIDTH]; always registered
//   busy      out  a ramp is in progress
//   upd_done  out  one-cycle pulse when all outputs reach the committed codes
//   wr_err    out  one-cycle pulse after an accepted write to a channel >= NCH
// -----------------------------------------------------------------------------
module avsddac_seq_ctrl #(
    parameter int NCH   = 4,
    parameter int WIDTH = 10,
    parameter int STEP  = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    avsddac_seq_ctrl_if.slave    wr,
    input  logic                 ldac,
    output logic [NCH*WIDTH-1:0] d_out,
    output logic                 busy,
    output logic                 upd_done,
    output logic                 wr_err
);
    localparam int           CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    // One extra bit so that a NCH equal to a power of two can be compared.
    localparam logic [CHW:0] NCH_LIM = (CHW+1)'(NCH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RAMP = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shadow_q [NCH];
    logic [WIDTH-1:0] shadow_d [NCH];
    logic [WIDTH-1:0] target_q [NCH];
    logic [WIDTH-1:0] target_d [NCH];
    logic [WIDTH-1:0] cur_q    [NCH];
    logic [WIDTH-1:0] cur_d    [NCH];
    logic             wr_err_q, wr_err_d;

    logic             wr_fire;
    logic             bad_ch;
    logic             all_done;

    // Moves cur toward tgt by at most STEP. The difference uses WIDTH+1 signed
    // bits so it cannot wrap. The result always lies between cur and tgt, so
    // it stays inside the code range.
    function automatic logic [WIDTH-1:0] step_toward(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] tgt
    );
        logic signed [WIDTH:0] diff;
        logic signed [WIDTH:0] lim;
        lim  = (WIDTH+1)'(STEP);
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > lim) begin
            step_toward = cur + WIDTH'(STEP);
        end else if (diff < -lim) begin
            step_toward = cur - WIDTH'(STEP);
        end else begin
            step_toward = tgt;
        end
    endfunction

    // The write port can always take data except during reset.
    assign wr.wr_ready = !reset;

    // Shadow write path. The FSM below reads shadow_d, so a write and an ldac
    // in the same cycle commit the new code.
    always_comb begin
        wr_fire  = wr.wr_valid && !reset;
        bad_ch   = ({1'b0, wr.wr_ch} >= NCH_LIM);
        shadow_d = shadow_q;
        if (wr_fire && !bad_ch) begin
            for (int i = 0; i < NCH; i++) begin
                if (wr.wr_ch == CHW'(i)) begin
                    shadow_d[i] = wr.wr_code;
                end
            end
        end
        wr_err_d = wr_fire && bad_ch;
    end

    // Commit / ramp sequencing
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cur_d    = cur_q;
        all_done = 1'b1;
`ifdef DAC_RAMP_EN
        case (state_q)
            IDLE: begin
                if (ldac) begin
                    target_d = shadow_d;
                    state_d  = RAMP;
                end
            end
            RAMP: begin
                for (int i = 0; i < NCH; i++) begin
                    cur_d[i] = step_toward(cur_q[i], target_q[i]);
                    if (cur_d[i] != target_q[i]) begin
                        all_done = 1'b0;
                    end
                end
                // A new ldac changes the target without restarting the ramp.
                // This edge still steps toward the old target.
                if (ldac) begin
                    target_d = shadow_d;
                end else if (all_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ldac) begin
                    target_d = shadow_d;
                    state_d  = RAMP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`else
        // Without the ramp a commit loads the outputs on the ldac edge, and
        // upd_done follows in the next cycle.
        case (state_q)
            IDLE, DONE: begin
                if (ldac) begin
                    target_d = shadow_d;
                    cur_d    = shadow_d;
                    state_d  = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            RAMP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_err_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
                target_q[i] <= '0;
                cur_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_err_q <= wr_err_d;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= shadow_d[i];
                target_q[i] <= target_d[i];
                cur_q[i]    <= cur_d[i];
            end
        end
    end

    // Output mapping
    always_comb begin
        d_out = '0;
        for (int i = 0; i < NCH; i++) begin
            d_out[i*WIDTH +: WIDTH] = cur_q[i];
        end
    end

`ifdef DAC_RAMP_EN
    assign busy = (state_q == RAMP);
`else
    assign busy = 1'b0;
`endif
    assign upd_done = (state_q == DONE);
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_avsddac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_avsddac_seq_ctrl
//
// Directed bench for avsddac_seq_ctrl with NCH=5, WIDTH=10 and STEP=8. A
// five-channel build gives unused channel indices 5..7 for the bad-channel
// case. A shadow model predicts the committed code set. Each commit pushes
// the expected d_out into a queue, and that entry is popped and compared when
// upd_done pulses. The ramp-specific sequences are built only when
// DAC_RAMP_EN is defined.
// -----------------------------------------------------------------------------
module tb_avsddac_seq_ctrl;
    localparam int NCH   = 5;
    localparam int WIDTH = 10;
    localparam int STEP  = 8;
    localparam int DW    = NCH * WIDTH;

    logic          CLK = 1'b0;
    logic          reset;
    logic          ldac;
    logic [DW-1:0] d_out;
    logic          busy;
    logic          upd_done;
    logic          wr_err;

    avsddac_seq_ctrl_if #(.NCH(NCH), .WIDTH(WIDTH)) wif ();

    avsddac_seq_ctrl #(.NCH(NCH), .WIDTH(WIDTH), .STEP(STEP)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .wr       (wif),
        .ldac     (ldac),
        .d_out    (d_out),
        .busy     (busy),
        .upd_done (upd_done),
        .wr_err   (wr_err)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] shadow_m [NCH];
    logic [DW-1:0]    exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_dout();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) r[i*WIDTH +: WIDTH] = shadow_m[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write(input int ch, input int code);
        wif.wr_valid = 1'b1;
        wif.wr_ch    = 3'(ch);
        wif.wr_code  = WIDTH'(code);
        tick();
        wif.wr_valid = 1'b0;
        if (ch < NCH) shadow_m[ch] = WIDTH'(code);
    endtask

    // Waits (bounded) for upd_done, compares d_out with the oldest expected
    // commit, then checks that the pulse is a single cycle.
    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        logic [DW-1:0] e;
        while (!upd_done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_upd"}, upd_done, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk({tag, "_dout"}, d_out, e);
        tick();
        chk({tag, "_upd_end"}, upd_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        wif.wr_valid = 1'b0;
        wif.wr_ch    = '0;
        wif.wr_code  = '0;
        ldac         = 1'b0;
        for (int i = 0; i < NCH; i++) shadow_m[i] = '0;

        // Reset with write and ldac both asserted
        reset        = 1'b1;
        wif.wr_valid = 1'b1;
        wif.wr_ch    = 3'd0;
        wif.wr_code  = 10'd55;
        ldac         = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_dout", d_out, 0);
            chk("rst_busy", busy, 0);
            chk("rst_upd", upd_done, 0);
            chk("rst_wr_err", wr_err, 0);
            chk("rst_ready", wif.wr_ready, 0);
        end
        reset        = 1'b0;
        wif.wr_valid = 1'b0;
        ldac         = 1'b0;
        #1;
        chk("ready_after_rst", wif.wr_ready, 1);
        // A commit right after reset must show that the shadows stayed at 0.
        ldac = 1'b1;
        exp_q.push_back(model_dout());
        tick();
        ldac = 1'b0;
        wait_done("rst_commit", 20);

        // Shadow writes do not reach d_out before a commit
        write(0, 100);
        chk("no_disturb", d_out, 0);

        // Commit ch0=100
        ldac = 1'b1;
        exp_q.push_back(model_dout());
        tick();
        ldac = 1'b0;
`ifdef DAC_RAMP_EN
        for (int k = 1; k <= 13; k++) begin
            chk("ramp_busy", busy, 1);
            tick();
            chk("ramp_ch0", d_out[0 +: WIDTH], (8*k > 100) ? 100 : 8*k);
        end
        chk("ramp_busy_end", busy, 0);
`else
        chk("byp_ch0", d_out[0 +: WIDTH], 100);
        chk("byp_busy", busy, 0);
`endif
        wait_done("commit_ch0", 20);

        // Full-scale code on ch3
        write(3, 1023);
        ldac = 1'b1;
        exp_q.push_back(model_dout());
        tick();
        ldac = 1'b0;
`ifndef DAC_RAMP_EN
        chk("fs_ch3", d_out[3*WIDTH +: WIDTH], 1023);
        chk("fs_upd", upd_done, 1);
        chk("fs_busy", busy, 0);
`endif
        wait_done("commit_fs", 200);
        chk("fs_busy_after", busy, 0);

`ifdef DAC_RAMP_EN
        // Down-ramp 500 -> 0, then retarget to 520 after three steps
        write(1, 500);
        ldac = 1'b1;
        exp_q.push_back(model_dout());
        tick();
        ldac = 1'b0;
        wait_done("ch1_500", 200);
        write(1, 0);
        ldac = 1'b1;
        tick();
        ldac = 1'b0;
        tick();
        chk("down1", d_out[WIDTH +: WIDTH], 492);
        tick();
        chk("down2", d_out[WIDTH +: WIDTH], 484);
        wif.wr_valid = 1'b1;
        wif.wr_ch    = 3'd1;
        wif.wr_code  = 10'd520;
        ldac         = 1'b1;
        tick();
        wif.wr_valid = 1'b0;
        ldac         = 1'b0;
        shadow_m[1]  = 10'd520;
        exp_q.push_back(model_dout());
        chk("down3", d_out[WIDTH +: WIDTH], 476);
        chk("retarget_busy", busy, 1);
        wait_done("retarget", 50);
`else
        // ldac while in DONE keeps committing, and upd_done pulses again
        wif.wr_valid = 1'b1;
        wif.wr_ch    = 3'd1;
        wif.wr_code  = 10'd500;
        ldac         = 1'b1;
        shadow_m[1]  = 10'd500;
        exp_q.push_back(model_dout());
        tick();
        chk("chain1_dout", d_out, exp_q.pop_front());
        chk("chain1_upd", upd_done, 1);
        wif.wr_code  = 10'd20;
        shadow_m[1]  = 10'd20;
        exp_q.push_back(model_dout());
        tick();
        wif.wr_valid = 1'b0;
        ldac         = 1'b0;
        chk("chain2_dout", d_out, exp_q.pop_front());
        chk("chain2_upd", upd_done, 1);
        tick();
        chk("chain_end_upd", upd_done, 0);
`endif

        // Write and ldac in the same cycle
        wif.wr_valid = 1'b1;
        wif.wr_ch    = 3'd2;
        wif.wr_code  = 10'd7;
        ldac         = 1'b1;
        shadow_m[2]  = 10'd7;
        exp_q.push_back(model_dout());
        tick();
        wif.wr_valid = 1'b0;
        ldac         = 1'b0;
        wait_done("same_cycle", 200);

        // Write to the highest valid channel
        write(4, 321);
        chk("ch4_no_err", wr_err, 0);

        // Writes to bad channels are dropped with a one-cycle wr_err
        write(5, 999);
        chk("bad5_err", wr_err, 1);
        tick();
        chk("bad5_err_end", wr_err, 0);
        write(7, 11);
        chk("bad7_err", wr_err, 1);
        ldac = 1'b1;
        exp_q.push_back(model_dout());
        tick();
        ldac = 1'b0;
        chk("bad_err_clear", wr_err, 0);
        wait_done("after_bad", 200);

        // Reset during an update aborts it without an upd_done
        write(0, 900);
        ldac = 1'b1;
        tick();
        ldac  = 1'b0;
        reset = 1'b1;
        tick();
        chk("abort_dout", d_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_upd", upd_done, 0);
        reset = 1'b0;
        for (int i = 0; i < NCH; i++) shadow_m[i] = '0;
        tick();
        chk("abort_upd2", upd_done, 0);
        ldac = 1'b1;
        exp_q.push_back(model_dout());
        tick();
        ldac = 1'b0;
        wait_done("post_abort", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
